// File: rtl/fir_seq_pkg.sv
// Shared types and sizing for the FIR stream sequencer.
// Latency: n/a (types, constants and a sizing helper only).
// Backpressure: n/a.
package fir_seq_pkg;

  localparam int SEQ_N = 16;
  localparam int SEQ_W = 24;

  // Prime counter must be able to hold the value N itself, not just N-1.
  localparam int PRIME_CNT_W = $clog2(SEQ_N + 1);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    FILT,
    WAIT_WR,
    PUSH
  } seq_state_t;

  function automatic int prime_cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_stream_sequencer_if.sv
// Codec stream and filter-pair signals bundled between sequencer and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: read_ready / write_ready gate the pop and push strobes.
interface fir_stream_sequencer_if
  import fir_seq_pkg::*;
#(
  parameter int W = SEQ_W
);

  logic                read_ready;
  logic signed [W-1:0] readdata_left;
  logic signed [W-1:0] readdata_right;
  logic                read;
  logic                write_ready;
  logic signed [W-1:0] writedata_left;
  logic signed [W-1:0] writedata_right;
  logic                write;
  logic signed [W-1:0] filt_in_left;
  logic signed [W-1:0] filt_in_right;
  logic                filt_wren;
  logic                filt_reen;
  logic signed [W-1:0] filt_out_left;
  logic signed [W-1:0] filt_out_right;

  // Sequencer side.
  modport master (
    input  read_ready, readdata_left, readdata_right, write_ready,
           filt_out_left, filt_out_right,
    output read, writedata_left, writedata_right, write,
           filt_in_left, filt_in_right, filt_wren, filt_reen
  );

  // Codec core and filter instances.
  modport slave (
    output read_ready, readdata_left, readdata_right, write_ready,
           filt_out_left, filt_out_right,
    input  read, writedata_left, writedata_right, write,
           filt_in_left, filt_in_right, filt_wren, filt_reen
  );

endinterface

// File: rtl/fir_stream_sequencer_prime_counter.sv
// Saturating count of samples pushed into the filter FIFOs, with registered at_max.
// Latency: at_max updates on the edge that makes the count reach MAX.
// Backpressure: none; inc beyond MAX is ignored, clr wins over inc.
module prime_counter
  import fir_seq_pkg::*;
#(
  parameter int MAX = SEQ_N,
  parameter int CW  = PRIME_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_max
);

  logic [CW-1:0] cnt;

  // Count up to MAX and hold; at_max is registered so primed is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      at_max <= 1'b0;
    end else if (clr) begin
      cnt    <= '0;
      at_max <= 1'b0;
    end else if (inc && !at_max) begin
      cnt    <= cnt + 1'b1;
      at_max <= (cnt == CW'(MAX - 1));
    end
  end

endmodule

// File: rtl/fir_stream_sequencer.sv
// Pops a stereo frame from the codec, steps the moving-average filters once, pushes the result.
// Latency: 3 cycles from the read strobe to the write strobe when write_ready is already high.
// Backpressure: holds in WAIT_WR with stable writedata until write_ready; no new pop meanwhile.
module fir_stream_sequencer
  import fir_seq_pkg::*;
#(
  parameter int N = SEQ_N,
  parameter int W = SEQ_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fir_stream_sequencer_if.master bus,
  input  logic                   bypass,
  input  logic                   flush,
  output logic                   primed
);

  seq_state_t state;
  logic       cnt_clr;
  logic       cnt_inc;
  logic       at_max;

  // Flush only restarts priming from IDLE; bypass frames never reach FILT so never count.
  assign cnt_clr = (state == IDLE) && flush;
  assign cnt_inc = (state == FILT);

  prime_counter #(
    .MAX (N),
    .CW  (prime_cnt_width(N))
  ) u_prime_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .at_max (at_max)
  );

  assign primed = at_max;

  // Frame FSM; strobes are set on entry to their state so each is a registered one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      bus.read            <= 1'b0;
      bus.write           <= 1'b0;
      bus.filt_wren       <= 1'b0;
      bus.filt_reen       <= 1'b0;
      bus.writedata_left  <= W'(0);
      bus.writedata_right <= W'(0);
      bus.filt_in_left    <= W'(0);
      bus.filt_in_right   <= W'(0);
    end else begin
      case (state)
        IDLE: begin
          if (!flush && bus.read_ready) begin
            state    <= POP;
            bus.read <= 1'b1;
          end
        end
        POP: begin
          bus.read          <= 1'b0;
          bus.filt_in_left  <= bus.readdata_left;
          bus.filt_in_right <= bus.readdata_right;
          if (bypass) begin
            bus.writedata_left  <= bus.readdata_left;
            bus.writedata_right <= bus.readdata_right;
            state               <= WAIT_WR;
          end else begin
            // at_max here equals the count seen during FILT: inc happens in FILT.
            bus.filt_wren <= 1'b1;
            bus.filt_reen <= at_max;
            state         <= FILT;
          end
        end
        FILT: begin
          bus.filt_wren       <= 1'b0;
          bus.filt_reen       <= 1'b0;
          bus.writedata_left  <= bus.filt_out_left;
          bus.writedata_right <= bus.filt_out_right;
          state               <= WAIT_WR;
        end
        WAIT_WR: begin
          if (bus.write_ready) begin
            bus.write <= 1'b1;
            state     <= PUSH;
          end
        end
        PUSH: begin
          bus.write <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          bus.read      <= 1'b0;
          bus.write     <= 1'b0;
          bus.filt_wren <= 1'b0;
          bus.filt_reen <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Directed bench: codec and a moving-average filter pair modelled around the sequencer.
// Latency: n/a.
// Backpressure: write_ready is driven low on purpose in selected frames.
module tb_fir_stream_sequencer;

  localparam int N = 16;
  localparam int W = 24;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bypass = 1'b0;
  logic flush = 1'b0;
  logic model_clr = 1'b1;
  logic primed;

  always #5 clk = ~clk;

  fir_stream_sequencer_if #(.W(W)) bus ();

  fir_stream_sequencer #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus    (bus),
    .bypass (bypass),
    .flush  (flush),
    .primed (primed)
  );

  int total = 0;
  int bad = 0;

  int read_cnt = 0;
  int write_cnt = 0;
  int wren_cnt = 0;
  int reen_cnt = 0;
  int width_err = 0;
  int overlap_err = 0;
  int stray_err = 0;
  logic read_q = 1'b0;
  logic write_q = 1'b0;
  logic wren_q = 1'b0;

  // Strobe monitor: pulse counts, pulse widths, read/write overlap, reen without wren.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.read) read_cnt <= read_cnt + 1;
      if (bus.write) write_cnt <= write_cnt + 1;
      if (bus.filt_wren) wren_cnt <= wren_cnt + 1;
      if (bus.filt_wren && bus.filt_reen) reen_cnt <= reen_cnt + 1;
      if ((bus.read && read_q) || (bus.write && write_q) || (bus.filt_wren && wren_q))
        width_err <= width_err + 1;
      if (bus.read && bus.write) overlap_err <= overlap_err + 1;
      if (bus.filt_reen && !bus.filt_wren) stray_err <= stray_err + 1;
    end
    read_q  <= bus.read;
    write_q <= bus.write;
    wren_q  <= bus.filt_wren;
  end

  // Moving-average filter pair: 16-entry FIFO, running sum, output = sum >>> 4.
  logic signed [W-1:0] ring_l [16];
  logic signed [W-1:0] ring_r [16];
  logic [3:0] wp = '0;
  longint acc_l = 0;
  longint acc_r = 0;
  longint sum_l;
  longint sum_r;

  always_comb begin
    sum_l = acc_l + longint'(bus.filt_in_left) - (bus.filt_reen ? longint'(ring_l[wp]) : 64'sd0);
    sum_r = acc_r + longint'(bus.filt_in_right) - (bus.filt_reen ? longint'(ring_r[wp]) : 64'sd0);
    bus.filt_out_left  = W'(sum_l >>> 4);
    bus.filt_out_right = W'(sum_r >>> 4);
  end

  always @(posedge clk) begin
    if (model_clr) begin
      acc_l <= 0;
      acc_r <= 0;
      wp    <= '0;
    end else if (bus.filt_wren) begin
      acc_l      <= sum_l;
      acc_r      <= sum_r;
      ring_l[wp] <= bus.filt_in_left;
      ring_r[wp] <= bus.filt_in_right;
      wp         <= wp + 1'b1;
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_read"}, bus.read, 0);
    chk({tag, "_write"}, bus.write, 0);
    chk({tag, "_wren"}, bus.filt_wren, 0);
    chk({tag, "_reen"}, bus.filt_reen, 0);
    chk({tag, "_primed"}, primed, 0);
    chk({tag, "_wd_l"}, bus.writedata_left, 0);
    chk({tag, "_wd_r"}, bus.writedata_right, 0);
    chk({tag, "_fi_l"}, bus.filt_in_left, 0);
    chk({tag, "_fi_r"}, bus.filt_in_right, 0);
  endtask

  // One full frame: offer it, wait for the pop, then for the push; returns what was written.
  task automatic run_frame(input logic signed [W-1:0] l, input logic signed [W-1:0] r,
                           input logic byp,
                           output logic signed [W-1:0] ol, output logic signed [W-1:0] orr,
                           output logic reen_seen, output logic wren_seen);
    int r0;
    int w0;
    r0 = reen_cnt;
    w0 = wren_cnt;
    bypass = byp;
    bus.readdata_left = l;
    bus.readdata_right = r;
    bus.read_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.read) break;
    end
    chk("frame_read", bus.read, 1);
    bus.read_ready = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.write) break;
    end
    chk("frame_write", bus.write, 1);
    ol = bus.writedata_left;
    orr = bus.writedata_right;
    reen_seen = (reen_cnt != r0);
    wren_seen = (wren_cnt != w0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic signed [W-1:0] ol;
    logic signed [W-1:0] orr;
    logic rs;
    logic ws;
    longint e;
    int r0;
    int wc;

    bus.read_ready = 1'b0;
    bus.write_ready = 1'b1;
    bus.readdata_left = '0;
    bus.readdata_right = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk_all_zero("rst");
    rst_n = 1'b1;
    model_clr = 1'b0;

    // Priming and DC ramp: output = min(k,16) * 0x100000 / 16.
    for (int k = 1; k <= 20; k++) begin
      run_frame(24'sh100000, -24'sh100000, 1'b0, ol, orr, rs, ws);
      e = (k > 16 ? 16 : k) * 64'sh10000;
      chk($sformatf("prime_reen_%0d", k), rs, (k > 16) ? 1 : 0);
      chk($sformatf("prime_out_l_%0d", k), ol, e);
      chk($sformatf("prime_out_r_%0d", k), orr, -e);
      if (k == 15 || k == 16) chk($sformatf("prime_primed_%0d", k), primed, (k == 16) ? 1 : 0);
    end
    @(negedge clk);
    chk("prime_read_cnt", read_cnt, 20);
    chk("prime_write_cnt", write_cnt, 20);
    chk("prime_width", width_err, 0);
    chk("prime_overlap", overlap_err, 0);

    // Backpressure, with flush asserted while busy (must be ignored).
    bus.write_ready = 1'b0;
    bus.readdata_left = 24'sh110000;
    bus.readdata_right = -24'sh100000;
    r0 = reen_cnt;
    bus.read_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.read) break;
    end
    chk("bp_read", bus.read, 1);
    bus.read_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.filt_wren) break;
    end
    chk("bp_wren", bus.filt_wren, 1);
    @(negedge clk);
    // 16*0x100000 + 0x110000 - 0x100000 = 0x1010000, /16 = 0x101000
    chk("bp_dat_l", bus.writedata_left, 64'sh101000);
    chk("bp_dat_r", bus.writedata_right, -64'sh100000);
    flush = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_l", bus.writedata_left, 64'sh101000);
      chk("bp_no_write", bus.write, 0);
      chk("bp_no_read", bus.read, 0);
    end
    flush = 1'b0;
    bus.write_ready = 1'b1;
    @(negedge clk);
    chk("bp_write", bus.write, 1);
    @(negedge clk);
    chk("bp_write_1cyc", bus.write, 0);
    chk("bp_flush_ignored", primed, 1);
    chk("bp_reen", reen_cnt - r0, 1);

    // Bypass while primed.
    run_frame(-24'sd5, 24'sh7FFFFF, 1'b1, ol, orr, rs, ws);
    chk("byp_l", ol, -5);
    chk("byp_r", orr, 64'sh7FFFFF);
    chk("byp_wren", ws, 0);
    chk("byp_primed", primed, 1);

    // Flush from IDLE; the integrator clears the filter FIFOs alongside.
    @(negedge clk);
    flush = 1'b1;
    model_clr = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    model_clr = 1'b0;
    chk("flush_primed", primed, 0);

    // Re-prime with a bypass frame in the middle; it must not advance the count.
    for (int k = 1; k <= 17; k++) begin
      if (k == 9) begin
        run_frame(24'sh001234, 24'sh004321, 1'b1, ol, orr, rs, ws);
        chk("reprime_byp_l", ol, 64'sh1234);
        chk("reprime_byp_wren", ws, 0);
        chk("reprime_byp_primed", primed, 0);
      end
      run_frame(24'sh100000, -24'sh100000, 1'b0, ol, orr, rs, ws);
      e = (k > 16 ? 16 : k) * 64'sh10000;
      chk($sformatf("reprime_reen_%0d", k), rs, (k == 17) ? 1 : 0);
      chk($sformatf("reprime_out_l_%0d", k), ol, e);
      if (k == 15 || k == 16) chk($sformatf("reprime_primed_%0d", k), primed, (k == 16) ? 1 : 0);
    end

    // Reset while a frame waits in WAIT_WR: it must be dropped.
    bus.write_ready = 1'b0;
    bypass = 1'b1;
    bus.readdata_left = 24'sh001000;
    bus.readdata_right = 24'sh002000;
    bus.read_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.read) break;
    end
    chk("mid_read", bus.read, 1);
    bus.read_ready = 1'b0;
    @(negedge clk);
    chk("mid_dat_l", bus.writedata_left, 64'sh1000);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("mid_rst");
    wc = write_cnt;
    bus.write_ready = 1'b1;
    bypass = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("mid_no_write", write_cnt, wc);
    chk("mid_primed", primed, 0);
    run_frame(24'sh100000, -24'sh100000, 1'b0, ol, orr, rs, ws);
    chk("mid_after_wren", ws, 1);
    chk("mid_after_reen", rs, 0);
    @(negedge clk);
    chk("end_width", width_err, 0);
    chk("end_overlap", overlap_err, 0);
    chk("end_stray_reen", stray_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
